// File: rtl/nic_fifo_if.sv
// rtl/nic_fifo_if.sv - processor and router bus bundle for nic_fifo
// Processor side: addr, d_in, nicEn, nicEnWR in; d_out out.
// Router side: net_si, net_di, net_ro, net_polarity in; net_ri, net_so, net_do out.
// Modport slave is the NIC view; modport master is the processor/router view.
interface nic_fifo_if #(
  parameter int W = 64
);
  logic [1:0]   addr;
  logic [0:W-1] d_in;
  logic [0:W-1] d_out;
  logic         nicEn;
  logic         nicEnWR;
  logic         net_si;
  logic         net_ri;
  logic [0:W-1] net_di;
  logic         net_so;
  logic         net_ro;
  logic [0:W-1] net_do;
  logic         net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/nic_fifo.sv
// rtl/nic_fifo.sv - network interface controller with DEPTH-entry FIFOs per direction
// Ports: clk (rising edge), reset (sync, active-high), bus (nic_fifo_if.slave).
// Input FIFO is filled by the router (net_si/net_di, net_ri = not full) and drained
// by processor reads of addr 00. Output FIFO is filled by processor writes to
// addr 10 and drained toward the router when net_ro is high and the head packet's
// VC bit matches net_polarity. Addr 01/11 return status words with sticky drop flags.
module nic_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4,
  parameter int VC_POS       = 0
) (
  input logic       clk,
  input logic       reset,
  nic_fifo_if.slave bus
);
  localparam int W  = PACKET_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [0:W-1]  r_in_mem  [DEPTH];
  logic [0:W-1]  r_out_mem [DEPTH];
  logic [PW-1:0] r_in_rptr, r_in_wptr, r_out_rptr, r_out_wptr;
  logic [CW-1:0] r_in_count, r_out_count;
  logic          r_in_drop, r_out_drop;
  logic [0:W-1]  r_d_out, r_net_do;
  logic          r_net_so;

  logic          w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic          w_rd, w_wr;
  logic          w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic          w_in_drop_evt, w_out_drop_evt;
  logic [0:W-1]  w_in_head, w_out_head;
  logic [0:W-1]  w_in_status, w_out_status;

  // All full/empty decisions come from the count registered at cycle start.
  assign w_in_full   = (r_in_count == CW'(DEPTH));
  assign w_in_empty  = (r_in_count == '0);
  assign w_out_full  = (r_out_count == CW'(DEPTH));
  assign w_out_empty = (r_out_count == '0);

  assign w_rd = bus.nicEn && !bus.nicEnWR;
  assign w_wr = bus.nicEn && bus.nicEnWR;

  assign w_in_head  = r_in_mem[r_in_rptr];
  assign w_out_head = r_out_mem[r_out_rptr];

  assign w_in_push      = bus.net_si && !w_in_full;
  assign w_in_drop_evt  = bus.net_si && w_in_full;
  assign w_in_pop       = w_rd && (bus.addr == 2'b00) && !w_in_empty;
  assign w_out_push     = w_wr && (bus.addr == 2'b10) && !w_out_full;
  assign w_out_drop_evt = w_wr && (bus.addr == 2'b10) && w_out_full;
  // Strict head-of-line: only the head's VC bit is ever considered.
  assign w_out_pop      = !w_out_empty && bus.net_ro && (w_out_head[VC_POS] == bus.net_polarity);

  // Status word: numerically (drop << 9) | (count << 1) | flag; bit W-1 is the LSB.
  assign w_in_status  = (W'(r_in_drop) << 9)  | (W'(r_in_count) << 1)  | W'(!w_in_empty);
  assign w_out_status = (W'(r_out_drop) << 9) | (W'(r_out_count) << 1) | W'(w_out_full);

  assign bus.net_ri = !w_in_full;
  assign bus.d_out  = r_d_out;
  assign bus.net_so = r_net_so;
  assign bus.net_do = r_net_do;

  // Storage is not reset; pointers and counts define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wptr]   <= bus.net_di;
    if (w_out_push) r_out_mem[r_out_wptr] <= bus.d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_rptr   <= '0;
      r_in_wptr   <= '0;
      r_out_rptr  <= '0;
      r_out_wptr  <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
      r_in_drop   <= 1'b0;
      r_out_drop  <= 1'b0;
      r_d_out     <= '0;
      r_net_so    <= 1'b0;
      r_net_do    <= '0;
    end else begin
      if (w_in_push)  r_in_wptr  <= r_in_wptr + 1'b1;
      if (w_in_pop)   r_in_rptr  <= r_in_rptr + 1'b1;
      if (w_out_push) r_out_wptr <= r_out_wptr + 1'b1;
      if (w_out_pop)  r_out_rptr <= r_out_rptr + 1'b1;

      r_in_count  <= r_in_count  + CW'(w_in_push)  - CW'(w_in_pop);
      r_out_count <= r_out_count + CW'(w_out_push) - CW'(w_out_pop);

      // A drop in the same cycle as the status read wins over the clear.
      if (w_in_drop_evt)
        r_in_drop <= 1'b1;
      else if (w_rd && bus.addr == 2'b01)
        r_in_drop <= 1'b0;

      if (w_out_drop_evt)
        r_out_drop <= 1'b1;
      else if (w_rd && bus.addr == 2'b11)
        r_out_drop <= 1'b0;

      if (w_rd) begin
        unique case (bus.addr)
          2'b00: r_d_out <= w_in_empty ? '0 : w_in_head;
          2'b01: r_d_out <= w_in_status;
          2'b10: r_d_out <= '0;
          2'b11: r_d_out <= w_out_status;
          default: r_d_out <= '0;
        endcase
      end

      r_net_so <= w_out_pop;
      r_net_do <= w_out_pop ? w_out_head : '0;
    end
  end
endmodule

// File: tb/tb_nic_fifo.sv
// tb/tb_nic_fifo.sv - self-checking bench for nic_fifo against a queue-based model
// No ports. Drives the nic_fifo_if instance directly, predicts outputs per edge.
module tb_nic_fifo;
  localparam int W      = 64;
  localparam int DEPTH  = 4;
  localparam int VC_POS = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nic_fifo_if #(.W(W)) bus ();

  nic_fifo #(.PACKET_WIDTH(W), .DEPTH(DEPTH), .VC_POS(VC_POS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] in_q[$];
  logic [63:0] out_q[$];
  bit          in_drop, out_drop;
  logic [63:0] exp_dout, exp_do;
  bit          exp_so;

  function automatic logic [63:0] status(bit drop, int count, bit flag);
    return (64'(drop) << 9) | (64'(count) << 1) | 64'(flag);
  endfunction

  // VC bit counted from the MSB, since bit 0 is the MSB of a packet.
  function automatic bit vc_of(logic [63:0] p);
    return p[W-1-VC_POS];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  in_n  = in_q.size();
    int  out_n = out_q.size();
    bit  rd    = bus.nicEn && !bus.nicEnWR;
    bit  wr    = bus.nicEn && bus.nicEnWR;
    logic [63:0] din  = bus.d_in;
    logic [63:0] ndi  = bus.net_di;
    if (reset) begin
      in_q.delete();
      out_q.delete();
      in_drop  = 0;
      out_drop = 0;
      exp_dout = '0;
      exp_so   = 0;
      exp_do   = '0;
      return;
    end
    if (rd) begin
      case (bus.addr)
        2'd0: exp_dout = (in_n != 0) ? in_q.pop_front() : 64'd0;
        2'd1: exp_dout = status(in_drop, in_n, in_n != 0);
        2'd2: exp_dout = 64'd0;
        default: exp_dout = status(out_drop, out_n, out_n == DEPTH);
      endcase
    end
    in_drop  = (bus.net_si && in_n == DEPTH) || (in_drop && !(rd && bus.addr == 2'd1));
    out_drop = (wr && bus.addr == 2'd2 && out_n == DEPTH) || (out_drop && !(rd && bus.addr == 2'd3));
    if (bus.net_si && in_n != DEPTH) in_q.push_back(ndi);
    if (out_n != 0 && bus.net_ro && vc_of(out_q[0]) == bus.net_polarity) begin
      exp_so = 1;
      exp_do = out_q.pop_front();
    end else begin
      exp_so = 0;
      exp_do = '0;
    end
    if (wr && bus.addr == 2'd2 && out_n != DEPTH) out_q.push_back(din);
  endtask

  // One clock: update the model at the edge, then compare all outputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("d_out",  bus.d_out,  exp_dout);
    chk("net_so", 64'(bus.net_so), 64'(exp_so));
    chk("net_do", bus.net_do, exp_do);
    chk("net_ri", 64'(bus.net_ri), 64'(in_q.size() != DEPTH));
  endtask

  task automatic idle();
    bus.nicEn   = 0;
    bus.nicEnWR = 0;
    bus.net_si  = 0;
  endtask

  task automatic proc_read(logic [1:0] a);
    bus.nicEn = 1; bus.nicEnWR = 0; bus.addr = a;
    step();
    bus.nicEn = 0;
  endtask

  task automatic proc_write(logic [1:0] a, logic [63:0] d);
    bus.nicEn = 1; bus.nicEnWR = 1; bus.addr = a; bus.d_in = d;
    step();
    bus.nicEn = 0; bus.nicEnWR = 0;
  endtask

  logic [63:0] pk [5];

  initial begin
    reset = 1;
    bus.addr = 0; bus.d_in = '0; bus.nicEn = 0; bus.nicEnWR = 0;
    bus.net_si = 0; bus.net_di = '0; bus.net_ro = 0; bus.net_polarity = 0;
    step();
    step();
    reset = 0;
    chk("rst_ri", 64'(bus.net_ri), 64'd1);
    chk("rst_so", 64'(bus.net_so), 64'd0);
    chk("rst_do", bus.net_do, 64'd0);
    proc_read(2'd1);
    chk("rst_in_status", bus.d_out, 64'd0);
    proc_read(2'd3);
    chk("rst_out_status", bus.d_out, 64'd0);

    // Fill the input FIFO and overflow it by one.
    for (int i = 0; i < 5; i++) pk[i] = 64'hA000_0000_0000_0000 + 64'(i);
    for (int i = 0; i < 5; i++) begin
      bus.net_si = 1; bus.net_di = pk[i];
      step();
      if (i == 3) chk("ri_full", 64'(bus.net_ri), 64'd0);
    end
    bus.net_si = 0;
    proc_read(2'd1);
    chk("in_status_drop", bus.d_out, 64'h209);
    proc_read(2'd1);
    chk("in_status_clr", bus.d_out, 64'h009);
    for (int i = 0; i < 4; i++) begin
      proc_read(2'd0);
      chk("in_pop", bus.d_out, pk[i]);
      if (i == 0) chk("ri_after_pop", 64'(bus.net_ri), 64'd1);
    end
    proc_read(2'd0);
    chk("in_pop_empty", bus.d_out, 64'd0);
    proc_read(2'd1);
    chk("in_status_empty", bus.d_out, 64'd0);

    // VC gating of the output head.
    bus.net_ro = 1; bus.net_polarity = 0;
    proc_write(2'd2, 64'hDEADBEEFDEADBEEF);
    proc_write(2'd2, 64'h0123456789ABCDEF);
    step();
    chk("vc_block_so", 64'(bus.net_so), 64'd0);
    bus.net_polarity = 1;
    step();
    chk("vc_send_so", 64'(bus.net_so), 64'd1);
    chk("vc_send_do", bus.net_do, 64'hDEADBEEFDEADBEEF);
    bus.net_polarity = 0;
    step();
    chk("vc_send2_do", bus.net_do, 64'h0123456789ABCDEF);

    // Output overflow, then drain in order.
    bus.net_ro = 0;
    for (int i = 0; i < 5; i++) proc_write(2'd2, 64'h1000 + 64'(i));
    proc_read(2'd3);
    chk("out_status_drop", bus.d_out, 64'h209);
    bus.net_ro = 1; bus.net_polarity = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_do", bus.net_do, 64'h1000 + 64'(i));
    end
    bus.net_ro = 0;
    proc_read(2'd3);
    chk("out_status_empty", bus.d_out, 64'd0);

    // Simultaneous push and pop keeps the count; reset discards contents.
    for (int i = 0; i < 2; i++) begin
      bus.net_si = 1; bus.net_di = 64'hB0 + 64'(i);
      step();
    end
    bus.net_di = 64'hB2;
    proc_read(2'd0);
    bus.net_si = 0;
    chk("pushpop_head", bus.d_out, 64'hB0);
    proc_read(2'd1);
    chk("pushpop_count", bus.d_out, 64'h005);
    bus.net_si = 1; bus.net_di = 64'hB3;
    step();
    bus.net_si = 0;
    reset = 1;
    step();
    reset = 0;
    proc_read(2'd1);
    chk("post_reset_status", bus.d_out, 64'd0);
    chk("post_reset_ri", 64'(bus.net_ri), 64'd1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 299) == 0);
      bus.nicEn        = $urandom_range(0, 1);
      bus.nicEnWR      = $urandom_range(0, 1);
      bus.addr         = 2'($urandom_range(0, 3));
      bus.d_in         = {$urandom, $urandom};
      bus.net_si       = ($urandom_range(0, 2) != 0);
      bus.net_di       = {$urandom, $urandom};
      bus.net_ro       = ($urandom_range(0, 2) != 0);
      bus.net_polarity = $urandom_range(0, 1);
      step();
    end
    reset = 0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nic_fifo.md
Name: nic_fifo

Overview:
- Parametrised successor to the single-entry network interface controller, sitting between one processor port and one mesh router port.
- Replaces the one-packet input and output buffers with DEPTH-entry FIFOs in each direction.
- Adds occupancy counts and sticky overflow flags to the status words.
- Gates output injection on the packet's virtual-channel bit versus router polarity.

Parameters:
PACKET_WIDTH, 64, packet/data width W; bit 0 is MSB ([0:W-1] ordering)
DEPTH, 4, entries per FIFO; power of two, 2..255
VC_POS, 0, bit index of the virtual-channel bit inside a packet

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
addr  in  2  processor register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status
d_in  in  W  processor write data
d_out  out  W  processor read data, registered
nicEn  in  1  processor access strobe
nicEnWR  in  1  1 = write, 0 = read (valid only with nicEn)
net_si  in  1  router send-in strobe
net_ri  out  1  NIC ready-in (input FIFO not full)
net_di  in  W  router packet in
net_so  out  1  NIC send-out strobe, registered
net_ro  in  1  router ready-out
net_do  out  W  packet to router, registered
net_polarity  in  1  router VC phase

Behaviour:
- Reset (sync, highest priority):
  - Pointers, counts and drop flags clear to 0; d_out=0, net_so=0, net_do=0.
  - net_ri=1 from the next cycle.
  - Reset mid-operation discards all FIFO contents.
- Pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
- Full/empty decisions use the registered count at cycle start, so a same-cycle pop never frees space for a same-cycle push.
- Input side:
  - net_ri = (in_count != DEPTH), combinational from count.
  - net_si=1 with net_ri=1: push net_di at the edge.
  - net_si=1 with net_ri=0: packet dropped, in_drop set.
- Processor read (nicEn=1, nicEnWR=0), 1-cycle latency to d_out:
  - 00: if input non-empty, d_out <= head and pop; if empty, d_out <= 0 and no pop.
  - 01: d_out <= in-status word, then in_drop clears at the same edge (a new drop in that cycle wins and keeps it set).
  - 10: d_out <= 0.
  - 11: d_out <= out-status word, then out_drop clears (same-cycle drop wins).
- Processor write (nicEn=1, nicEnWR=1):
  - 10: push d_in to the output FIFO if not full; if full, word is dropped and out_drop is set.
  - Writes to 00/01/11 are ignored.
  - d_out holds during writes.
- nicEn=0: d_out holds its last value.
- Status word, all other bits 0:
  - bit W-1 = flag (in-status: input non-empty; out-status: output full).
  - bits W-9..W-2 = 8-bit count, LSB at W-2.
  - bit W-10 = sticky drop flag.
  - For W=64, the value is (drop<<9) | (count<<1) | flag.
- Output side, evaluated every cycle:
  - Send when out_count!=0 and net_ro=1 and head[VC_POS]==net_polarity.
  - On send: net_so <= 1, net_do <= head, pop.
  - Otherwise net_so <= 0 and net_do <= 0.
  - Strict head-of-line: a head with mismatched VC blocks later entries.
- Simultaneous push and pop on the same FIFO (non-full, non-empty): both occur, count unchanged.

Test Plan:
- Reset, then read 01 and 11 -> d_out=0 both; net_ri=1, net_so=0, net_do=0.
- Router pushes A0..A3 on 4 consecutive cycles, then a 5th packet A4 -> net_ri=0 after the 4th push; A4 dropped; read 01 -> 64'h209; read 01 again -> 64'h009.
- Four reads of addr 00 -> d_out=A0,A1,A2,A3 one cycle after each; net_ri=1 after the first pop; a 5th read -> d_out=0, read 01 -> 0.
- Write 64'hDEADBEEFDEADBEEF then 64'h0123456789ABCDEF to addr 10, net_ro=1:
  - polarity=0 -> net_so=0 (head VC=1 blocks).
  - polarity=1 -> net_so=1, net_do=DEAD...; next cycle polarity=0 -> net_do=0123....
- net_ro=0, five writes to addr 10 -> 5th dropped; read 11 -> 64'h209; raise net_ro with matching polarity -> four sends in order, count 0.
- Input count=2, net_si=1 and addr-00 read in the same cycle -> count stays 2, head advances; reset asserted while count=3 -> next read 01 = 0, net_ri=1.
